// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side signal bundle: serial line and tick in, received word and status out.
// master drives the line and tick; slave is the receiver.
interface uart_rx_oversampled_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            framing_err;

    modport master (
        output rx,
        output s_tick,
        input  rx_dout,
        input  rx_done_tick,
        input  framing_err
    );

    modport slave (
        input  rx,
        input  s_tick,
        output rx_dout,
        output rx_done_tick,
        output framing_err
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// UART receiver using a 16x oversampling tick; LSB-first data, configurable stop length.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronised line
// START | counting to the middle of the start bit, rejecting glitches
// DATA  | sampling DBIT data bits at their centres
// STOP  | sampling the first stop bit, then waiting out SB_TICK ticks
module uart_rx_oversampled #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_rx_oversampled_if.slave  bus
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic            rx_meta, rx_s;
    logic [4:0]      s_cnt, s_cnt_next;
    logic [NW-1:0]   n_cnt, n_cnt_next;
    logic [DBIT-1:0] shift, shift_next;
    logic [DBIT-1:0] dout, dout_next;
    logic            stop_bit, stop_bit_next;
    logic            ferr, ferr_next;
    logic            done, done_next;

    logic mid_tick, bit_tick, stop_end, last_data;

    assign mid_tick  = bus.s_tick && (s_cnt == 5'd7);
    assign bit_tick  = bus.s_tick && (s_cnt == 5'd15);
    assign stop_end  = bus.s_tick && (s_cnt == 5'(SB_TICK - 1));
    assign last_data = (n_cnt == NW'(DBIT - 1));

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            s_cnt    <= '0;
            n_cnt    <= '0;
            shift    <= '0;
            dout     <= '0;
            stop_bit <= 1'b0;
            ferr     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            s_cnt    <= s_cnt_next;
            n_cnt    <= n_cnt_next;
            shift    <= shift_next;
            dout     <= dout_next;
            stop_bit <= stop_bit_next;
            ferr     <= ferr_next;
            done     <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rx_s)                  state_next = START;
            START: if (mid_tick)               state_next = rx_s ? IDLE : DATA;
            DATA:  if (bit_tick && last_data)  state_next = STOP;
            STOP:  if (stop_end)               state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    always_comb begin
        s_cnt_next    = s_cnt;
        n_cnt_next    = n_cnt;
        shift_next    = shift;
        dout_next     = dout;
        stop_bit_next = stop_bit;
        ferr_next     = ferr;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) s_cnt_next = '0;
            end
            START: begin
                if (mid_tick) begin
                    s_cnt_next = '0;
                    n_cnt_next = '0;
                end else if (bus.s_tick) begin
                    s_cnt_next = s_cnt + 5'd1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    s_cnt_next = '0;
                    shift_next = {rx_s, shift[DBIT-1:1]};
                    if (!last_data) n_cnt_next = n_cnt + NW'(1);
                end else if (bus.s_tick) begin
                    s_cnt_next = s_cnt + 5'd1;
                end
            end
            STOP: begin
                // Stop level is captured mid-bit; the remaining ticks only pace the frame.
                if (mid_tick) stop_bit_next = rx_s;
                if (stop_end) begin
                    s_cnt_next = '0;
                    dout_next  = shift;
                    ferr_next  = ~stop_bit;
                    done_next  = 1'b1;
                end else if (bus.s_tick) begin
                    s_cnt_next = s_cnt + 5'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.rx_dout      = dout;
    assign bus.rx_done_tick = done;
    assign bus.framing_err  = ferr;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench: the sender queues the expected word per frame; monitors pop on each strobe.
module tb_uart_rx_oversampled;
    logic clk = 1'b0;
    logic reset_n;
    logic s_tick;
    logic rx_a, rx_b;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    typedef struct {
        logic [8:0] data;
        logic       ferr;
        int         start;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    uart_rx_oversampled_if #(.DBIT(8)) bus_a ();
    uart_rx_oversampled_if #(.DBIT(7)) bus_b ();

    assign bus_a.rx     = rx_a;
    assign bus_a.s_tick = s_tick;
    assign bus_b.rx     = rx_b;
    assign bus_b.s_tick = s_tick;

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    uart_rx_oversampled #(.DBIT(7), .SB_TICK(32)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One tick every 4 clk: 64 clk per bit period.
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Both variants need 152 ticks from start detection to the final stop tick.
    task automatic check_latency(input string name, input int lat);
        n_total++;
        if (lat >= 606 && lat <= 614) n_pass++;
        else $display("FAIL %s: got %0d clk, expected 606..614 clk", name, lat);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx_a = v;
        else            rx_b = v;
        wait_clk(n);
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int nstop, input int stop_low);
        exp_t e;
        e.data  = data;
        e.ferr  = (stop_low > 0);
        e.start = cyc;
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
        drive(which, 1'b0, 64);
        for (int i = 0; i < nbits; i++) drive(which, data[i], 64);
        if (stop_low > 0) begin
            drive(which, 1'b0, stop_low);
            drive(which, 1'b1, 64 * nstop - stop_low);
        end else begin
            drive(which, 1'b1, 64 * nstop);
        end
    endtask

    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_a.rx_done_tick) begin
                check("a_strobe_width", {31'd0, prev}, 32'd0);
                if (q_a.size() == 0) begin
                    n_total++;
                    $display("FAIL a_unexpected_strobe: got rx_dout=0x%0h, expected no strobe", bus_a.rx_dout);
                end else begin
                    e = q_a.pop_front();
                    check("a_rx_dout", {23'd0, 1'b0, bus_a.rx_dout}, {23'd0, e.data});
                    check("a_framing_err", {31'd0, bus_a.framing_err}, {31'd0, e.ferr});
                    check_latency("a_latency", cyc - e.start);
                end
            end
            prev = bus_a.rx_done_tick;
        end
    end

    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_b.rx_done_tick) begin
                check("b_strobe_width", {31'd0, prev}, 32'd0);
                if (q_b.size() == 0) begin
                    n_total++;
                    $display("FAIL b_unexpected_strobe: got rx_dout=0x%0h, expected no strobe", bus_b.rx_dout);
                end else begin
                    e = q_b.pop_front();
                    check("b_rx_dout", {23'd0, 2'b0, bus_b.rx_dout}, {23'd0, e.data});
                    check("b_framing_err", {31'd0, bus_b.framing_err}, {31'd0, e.ferr});
                    check_latency("b_latency", cyc - e.start);
                end
            end
            prev = bus_b.rx_done_tick;
        end
    end

    initial begin
        reset_n = 1'b0;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        wait_clk(5);
        check("reset_a_dout", {24'd0, bus_a.rx_dout}, 32'h0);
        check("reset_a_done", {31'd0, bus_a.rx_done_tick}, 32'h0);
        check("reset_a_ferr", {31'd0, bus_a.framing_err}, 32'h0);
        reset_n = 1'b1;
        wait_clk(20);

        send_frame(0, 9'h0A5, 8, 1, 0);
        wait_clk(64);

        send_frame(0, 9'h000, 8, 1, 0);
        send_frame(0, 9'h0FF, 8, 1, 0);
        send_frame(0, 9'h055, 8, 1, 0);
        wait_clk(128);

        // Three tick periods low: must be rejected at the start-bit midpoint.
        drive(0, 1'b0, 12);
        drive(0, 1'b1, 128);
        send_frame(0, 9'h03C, 8, 1, 0);
        wait_clk(64);

        // Stop bit low through its sample point, then back high before the frame ends.
        send_frame(0, 9'h081, 8, 1, 48);
        wait_clk(128);
        send_frame(0, 9'h042, 8, 1, 0);
        wait_clk(64);

        send_frame(1, 9'h05A, 7, 2, 0);
        send_frame(1, 9'h025, 7, 2, 0);
        wait_clk(64);

        // Abort 0x99 partway through its data bits.
        drive(0, 1'b0, 64);
        drive(0, 1'b1, 64);
        drive(0, 1'b0, 64);
        drive(0, 1'b0, 64);
        reset_n = 1'b0;
        wait_clk(2);
        check("midreset_a_dout", {24'd0, bus_a.rx_dout}, 32'h0);
        check("midreset_a_done", {31'd0, bus_a.rx_done_tick}, 32'h0);
        check("midreset_a_ferr", {31'd0, bus_a.framing_err}, 32'h0);
        check("midreset_b_dout", {25'd0, bus_b.rx_dout}, 32'h0);
        rx_a = 1'b1;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(64);
        send_frame(0, 9'h0C3, 8, 1, 0);

        for (int i = 0; i < 2000 && (q_a.size() != 0 || q_b.size() != 0); i++) wait_clk(1);
        wait_clk(20);
        check("a_pending_frames", q_a.size(), 32'd0);
        check("b_pending_frames", q_b.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
